// File: rtl/segment_stream_packer.sv
// Snapshots ten expansion-stage segment words on start and streams them out
// in index order over valid/ready, reporting the frame sum on completion.
module segment_stream_packer #(
  parameter int DATA_W = 32,
  parameter int SUM_W  = DATA_W + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] segment_0,
  input  logic [DATA_W-1:0] segment_1,
  input  logic [DATA_W-1:0] segment_2,
  input  logic [DATA_W-1:0] segment_3,
  input  logic [DATA_W-1:0] segment_4,
  input  logic [DATA_W-1:0] segment_5,
  input  logic [DATA_W-1:0] segment_6,
  input  logic [DATA_W-1:0] segment_7,
  input  logic [DATA_W-1:0] segment_8,
  input  logic [DATA_W-1:0] segment_9,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_out
);

  localparam int         NSEG     = 10;
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   bank_q [0:NSEG-1];
  logic [DATA_W-1:0]   seg_w  [0:NSEG-1];
  logic [SUM_W-1:0]    acc_q;
  logic [SUM_W-1:0]    acc_d;
  logic [SUM_W-1:0]    sum_q;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          index_q;
  logic [3:0]          index_d;
  logic                last_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                xfer;

  function automatic logic [SUM_W-1:0] zext(input logic [DATA_W-1:0] w);
    return {{(SUM_W-DATA_W){1'b0}}, w};
  endfunction

  assign seg_w[0] = segment_0;
  assign seg_w[1] = segment_1;
  assign seg_w[2] = segment_2;
  assign seg_w[3] = segment_3;
  assign seg_w[4] = segment_4;
  assign seg_w[5] = segment_5;
  assign seg_w[6] = segment_6;
  assign seg_w[7] = segment_7;
  assign seg_w[8] = segment_8;
  assign seg_w[9] = segment_9;

  assign xfer    = valid_q && out_ready;
  assign acc_d   = acc_q + zext(data_q);
  assign index_d = index_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NSEG; i++) bank_q[i] <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // start is honoured even in the done cycle, giving a one-cycle frame gap
          if (start) begin
            for (int i = 0; i < NSEG; i++) bank_q[i] <= seg_w[i];
            acc_q   <= '0;
            index_q <= '0;
            data_q  <= segment_0;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (index_q == LAST_IDX) begin
              sum_q   <= acc_d;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              acc_q   <= acc_d;
              index_q <= index_d;
              data_q  <= bank_q[index_d];
              last_q  <= (index_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_segment_stream_packer.sv
// Bench for segment_stream_packer: queue-based frame model checked every cycle,
// plus directed frames with hand-computed sums and cycle counts.
module tb_segment_stream_packer;

  localparam int DATA_W = 32;
  localparam int SUM_W  = 36;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              out_ready;
  logic [DATA_W-1:0] seg [10];
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum_out;

  int total = 0;
  int bad   = 0;

  // Frame model: remaining words of the current frame in a queue
  bit                m_busy = 0;
  bit                m_done = 0;
  logic [DATA_W-1:0] m_words [$];
  int                m_pos  = 0;
  logic [SUM_W-1:0]  m_run  = '0;
  logic [SUM_W-1:0]  m_sum  = '0;

  segment_stream_packer #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .segment_0(seg[0]), .segment_1(seg[1]), .segment_2(seg[2]), .segment_3(seg[3]),
    .segment_4(seg[4]), .segment_5(seg[5]), .segment_6(seg[6]), .segment_7(seg[7]),
    .segment_8(seg[8]), .segment_9(seg[9]),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
    .sum_out(sum_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      m_busy = 0; m_done = 0; m_words.delete(); m_pos = 0; m_run = '0; m_sum = '0;
      chk("rst_data", out_data, 0);
      chk("rst_index", 64'(out_index), 0);
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_words.delete();
          for (int k = 0; k < 10; k++) m_words.push_back(seg[k]);
          m_pos = 0; m_run = '0; m_busy = 1;
        end
      end else if (out_ready) begin
        m_run = m_run + SUM_W'(m_words.pop_front());
        m_pos++;
        if (m_words.size() == 0) begin
          m_sum = m_run; m_busy = 0; m_done = 1;
        end
      end
    end
    chk("m_valid", 64'(out_valid), 64'(m_busy));
    chk("m_busy", 64'(busy), 64'(m_busy));
    chk("m_done", 64'(done), 64'(m_done));
    chk("m_sum", 64'(sum_out), 64'(m_sum));
    chk("m_last", 64'(out_last), 64'(m_busy && m_pos == 9));
    if (m_busy) begin
      chk("m_data", 64'(out_data), 64'(m_words[0]));
      chk("m_index", 64'(out_index), 64'(m_pos));
    end
  end

  task automatic set_ramp(input logic [DATA_W-1:0] mult);
    for (int k = 0; k < 10; k++) seg[k] = mult * DATA_W'(k + 1);
  endtask

  task automatic set_const(input logic [DATA_W-1:0] v);
    for (int k = 0; k < 10; k++) seg[k] = v;
  endtask

  // Returns at the first negedge where the new frame's word 0 is visible
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Runs until done is seen; counts negedges with out_valid high
  task automatic run_frame(input bit toggle, input string tag, output int vcnt);
    bit got;
    got  = 0;
    vcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) vcnt++;
      if (done) begin got = 1; break; end
      out_ready = toggle ? ~out_ready : 1'b1;
      @(negedge clk);
    end
    chk({tag, "_timeout"}, 64'(got), 1);
  endtask

  initial begin
    int vc;
    int vcount, dcount, gapbad;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    set_const('0);
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(out_valid), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_sum", 64'(sum_out), 0);
    chk("reset_last", 64'(out_last), 0);
    reset = 1'b1;

    // Basic frame, ready always high
    set_ramp(1); out_ready = 1'b1;
    pulse_start();
    chk("t1_first_data", 64'(out_data), 1);
    run_frame(0, "t1", vc);
    chk("t1_vcnt", 64'(vc), 10);
    chk("t1_sum", 64'(sum_out), 55);
    chk("t1_busy", 64'(busy), 0);

    // Ready toggling 0,1,0,1... from the first valid cycle
    out_ready = 1'b1;
    pulse_start();
    run_frame(1, "t2", vc);
    chk("t2_vcnt", 64'(vc), 20);
    chk("t2_sum", 64'(sum_out), 55);
    out_ready = 1'b1;

    // Maximal words
    set_const(32'hFFFF_FFFF);
    pulse_start();
    run_frame(0, "t3", vc);
    chk("t3_vcnt", 64'(vc), 10);
    chk("t3_sum", 64'(sum_out), 64'h9_FFFF_FFF6);

    // Restart attempt mid-frame with changed segments
    set_ramp(1);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t4_index", 64'(out_index), 3);
    chk("t4_data", 64'(out_data), 4);
    set_const(32'hAAAA_AAAA); start = 1'b1;
    @(negedge clk); start = 1'b0;
    run_frame(0, "t4", vc);
    chk("t4_sum", 64'(sum_out), 55);

    // Asynchronous reset mid-frame
    set_ramp(1);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("t5_index", 64'(out_index), 4);
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", 64'(out_valid), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_data", 64'(out_data), 0);
    chk("t5_sum", 64'(sum_out), 0);
    chk("t5_done", 64'(done), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t5_nodone", 64'(done), 0);
    pulse_start();
    run_frame(0, "t5", vc);
    chk("t5_vcnt", 64'(vc), 10);
    chk("t5_sum2", 64'(sum_out), 55);

    // start held high: back-to-back frames with one done cycle between
    @(negedge clk); start = 1'b1;
    vcount = 0; dcount = 0; gapbad = 0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
      if (done) dcount++;
      if (out_valid == done) gapbad++;
      if (i == 11) begin chk("t6_sum1", 64'(sum_out), 55);  set_ramp(2); end
      if (i == 22) begin chk("t6_sum2", 64'(sum_out), 110); set_ramp(3); end
      if (i == 33) begin chk("t6_sum3", 64'(sum_out), 165); start = 1'b0; end
    end
    chk("t6_vcount", 64'(vcount), 30);
    chk("t6_dcount", 64'(dcount), 3);
    chk("t6_gap", 64'(gapbad), 0);
    repeat (2) @(negedge clk);
    chk("t6_idle_busy", 64'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
